exe_stage_pipe: RTL

Parametrised next-generation execute stage for the five-stage MIPS pipeline. It contains operand forwarding from MEM/WB, load-use and multi-cycle stall generation, a wider ALU operation set and the EX/MEM pipeline register. It sits between the ID/EX register and the data-memory stage. Its registered MEM_* outputs feed data memory and are also its own MEM-stage forwarding source.

---
 rtl/exe_stage_pipe.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/exe_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage_pipe
// Purpose  : MIPS execute stage with MEM/WB forwarding, hazard stalls, ALU and
//            EX/MEM register. Optional shift-add multiplier under EXE_MUL_EN.
// Revision : 1.0  initial release
// ============================================================================
module exe_stage_pipe #(
    parameter int DW         = 32,
    parameter int RW         = 5,
    parameter int MUL_CYCLES = DW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          EXE_Valid,
    input  logic [RW-1:0] EXE_Rs,
    input  logic [RW-1:0] EXE_Rt,
    input  logic [RW-1:0] EXE_Rd,
    input  logic          EXE_RegDst,
    input  logic [DW-1:0] EXE_BusA,
    input  logic [DW-1:0] EXE_BusB,
    input  logic [DW-1:0] EXE_Imm,
    input  logic          EXE_ALUSrc,
    input  logic [3:0]    EXE_ALUctr,
    input  logic          EXE_RegWr,
    input  logic          EXE_MemWr,
    input  logic          EXE_MemtoReg,
    input  logic [RW-1:0] WB_Rw,
    input  logic          WB_RegWr,
    input  logic [DW-1:0] WB_BusW,
    output logic          Stall,
    output logic          MEM_Valid,
    output logic [DW-1:0] MEM_Result,
    output logic [DW-1:0] MEM_BusB,
    output logic [RW-1:0] MEM_Rw,
    output logic          MEM_RegWr,
    output logic          MEM_MemWr,
    output logic          MEM_MemtoReg,
    output logic          MEM_Zero,
    output logic          MEM_Overflow
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_LUI  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;

    logic          mem_fwd_ok;
    logic [DW-1:0] op_a;
    logic [DW-1:0] fwd_b;
    logic [DW-1:0] alu_b;
    logic          use_rt;
    logic          load_use;
    logic [DW-1:0] sum;
    logic [DW-1:0] diff;
    logic [DW-1:0] alu_res;
    logic          alu_ovf;
    logic [RW-1:0] rw_sel;
    logic          mul_stall;
    logic          mul_done;
    logic [DW-1:0] mul_result;

    // Loads are not forwardable from MEM: their data only exists after memory.
    assign mem_fwd_ok = MEM_Valid & MEM_RegWr & ~MEM_MemtoReg;

    always_comb begin
        op_a = EXE_BusA;
        if ((EXE_Rs != '0) && mem_fwd_ok && (MEM_Rw == EXE_Rs)) begin
            op_a = MEM_Result;
        end else if ((EXE_Rs != '0) && WB_RegWr && (WB_Rw == EXE_Rs)) begin
            op_a = WB_BusW;
        end
    end

    always_comb begin
        fwd_b = EXE_BusB;
        if ((EXE_Rt != '0) && mem_fwd_ok && (MEM_Rw == EXE_Rt)) begin
            fwd_b = MEM_Result;
        end else if ((EXE_Rt != '0) && WB_RegWr && (WB_Rw == EXE_Rt)) begin
            fwd_b = WB_BusW;
        end
    end

    assign alu_b  = EXE_ALUSrc ? EXE_Imm : fwd_b;
    assign rw_sel = EXE_RegDst ? EXE_Rd : EXE_Rt;

    assign use_rt   = ~EXE_ALUSrc | EXE_MemWr;
    assign load_use = EXE_Valid & MEM_Valid & MEM_MemtoReg & MEM_RegWr &
                      (MEM_Rw != '0) &
                      ((MEM_Rw == EXE_Rs) | (use_rt & (MEM_Rw == EXE_Rt)));

    assign sum  = op_a + alu_b;
    assign diff = op_a - alu_b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (EXE_ALUctr)
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (op_a[DW-1] == alu_b[DW-1]) && (sum[DW-1] != op_a[DW-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (op_a[DW-1] != alu_b[DW-1]) && (diff[DW-1] != op_a[DW-1]);
            end
            ALU_AND:  alu_res = op_a & alu_b;
            ALU_OR:   alu_res = op_a | alu_b;
            ALU_XOR:  alu_res = op_a ^ alu_b;
            ALU_NOR:  alu_res = ~(op_a | alu_b);
            ALU_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
            ALU_SLTU: alu_res = {{(DW-1){1'b0}}, (op_a < alu_b)};
            ALU_LUI:  alu_res = alu_b << (DW/2);
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

`ifdef EXE_MUL_EN
    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;
    // Bits of the multiplier retired per BUSY cycle so MUL_CYCLES covers DW.
    localparam int BPC = (DW + MUL_CYCLES - 1) / MUL_CYCLES;
    localparam int CW  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [1:0]    mul_state;
    logic [CW-1:0] mul_cnt;
    logic [DW-1:0] mcand;
    logic [DW-1:0] mplier;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_next;
    logic          mul_start;

    assign mul_start = EXE_Valid & (EXE_ALUctr == ALU_MUL) & ~load_use &
                       (mul_state == MUL_IDLE);

    always_comb begin
        acc_next = acc;
        for (int k = 0; k < BPC; k++) begin
            if (mplier[k]) begin
                acc_next = acc_next + (mcand << k);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mul_state <= MUL_IDLE;
            mul_cnt   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
        end else begin
            case (mul_state)
                MUL_IDLE: begin
                    if (mul_start) begin
                        mcand     <= op_a;
                        mplier    <= alu_b;
                        acc       <= '0;
                        mul_cnt   <= '0;
                        mul_state <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << BPC;
                    mplier <= mplier >> BPC;
                    if (mul_cnt == CW'(MUL_CYCLES - 1)) begin
                        mul_state <= MUL_DONE;
                    end else begin
                        mul_cnt <= mul_cnt + CW'(1);
                    end
                end
                MUL_DONE: mul_state <= MUL_IDLE;
                default:  mul_state <= MUL_IDLE;
            endcase
        end
    end

    assign mul_stall  = mul_start | (mul_state == MUL_BUSY);
    assign mul_done   = (mul_state == MUL_DONE);
    assign mul_result = acc;
`else
    assign mul_stall  = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
`endif

    assign Stall = ~Reset & (load_use | mul_stall);

    // The held MUL instruction is still on the EXE inputs in its finish cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            MEM_Valid    <= 1'b0;
            MEM_Result   <= '0;
            MEM_BusB     <= '0;
            MEM_Rw       <= '0;
            MEM_RegWr    <= 1'b0;
            MEM_MemWr    <= 1'b0;
            MEM_MemtoReg <= 1'b0;
            MEM_Zero     <= 1'b0;
            MEM_Overflow <= 1'b0;
        end else if (mul_done) begin
            MEM_Valid    <= EXE_Valid;
            MEM_Result   <= mul_result;
            MEM_BusB     <= fwd_b;
            MEM_Rw       <= rw_sel;
            MEM_RegWr    <= EXE_Valid & EXE_RegWr;
            MEM_MemWr    <= EXE_Valid & EXE_MemWr;
            MEM_MemtoReg <= EXE_Valid & EXE_MemtoReg;
            MEM_Zero     <= (mul_result == '0);
            MEM_Overflow <= 1'b0;
        end else if (load_use | mul_stall | ~EXE_Valid) begin
            MEM_Valid    <= 1'b0;
            MEM_Result   <= '0;
            MEM_BusB     <= '0;
            MEM_Rw       <= '0;
            MEM_RegWr    <= 1'b0;
            MEM_MemWr    <= 1'b0;
            MEM_MemtoReg <= 1'b0;
            MEM_Zero     <= 1'b0;
            MEM_Overflow <= 1'b0;
        end else begin
            MEM_Valid    <= 1'b1;
            MEM_Result   <= alu_res;
            MEM_BusB     <= fwd_b;
            MEM_Rw       <= rw_sel;
            MEM_RegWr    <= EXE_RegWr & ~alu_ovf;
            MEM_MemWr    <= EXE_MemWr;
            MEM_MemtoReg <= EXE_MemtoReg;
            MEM_Zero     <= (alu_res == '0);
            MEM_Overflow <= alu_ovf;
        end
    end

endmodule
`default_nettype wire
